// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD conversion blocks.
// The reverse converter uses the >=8 / -3 adjust. The forward
// binary-to-BCD stage uses the >=5 / +3 adjust.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_SUB    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT  = 4'd9;

    localparam logic [BCD_DIGIT_W-1:0] BCD_FWD_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] BCD_FWD_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step for reverse double dabble.
// It subtracts 3 from a digit that is 8 or more, in 4 bits with no carry out.
//   digit_in  : digit after the right shift
//   digit_out : corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) digit_out = digit_in - BCD_ADJ_SUB;
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per clock).
//   clk, rst : clock and asynchronous active-high reset
//   start    : request a conversion, sampled while ready=1
//   bcd_in   : packed BCD digits, [3:0] holds the units
//   ready    : idle and able to accept start
//   valid    : one-cycle pulse when bin_out/err are final
//   bin_out  : converted value, loaded when the result becomes final
//   err      : the accepted input had a digit above 9
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SHIFT | one shift/adjust iteration per clock, BIN_W iterations in total
// DONE  | result presented, valid=1 for one cycle
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  valid,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    generate
        if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : g_width_check
            $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
        end
    endgenerate

    bcd_state_t          state, state_nxt;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   shifted;
    logic [WORK_W-1:0]   work_adj;
    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    cnt;
    logic                last;
    logic                bad_digit;

    assign shifted  = work >> 1;
    assign work_adj = {bcd_adj, shifted[BIN_W-1:0]};
    assign last     = (cnt == CNT_W'(BIN_W - 1));

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (shifted[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad_digit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = bad_digit ? DONE : SHIFT;
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                valid     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= {bcd_in, {BIN_W{1'b0}}};
                        cnt  <= '0;
                        err  <= bad_digit;
                        // An illegal entry skips SHIFT, so its result is loaded here.
                        if (bad_digit) bin_out <= '0;
                    end
                end
                SHIFT: begin
                    work <= work_adj;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) bin_out <= work_adj[BIN_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;
    import bcd_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        ready;
    logic        valid;
    logic [9:0]  bin_out;
    logic        err;

    int checks;
    int failures;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .ready   (ready),
        .valid   (valid),
        .bin_out (bin_out),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] b;
        b[11:8] = 4'(n / 100);
        b[7:4]  = 4'((n / 10) % 10);
        b[3:0]  = 4'(n % 10);
        return b;
    endfunction

    // Forward shift-add-3 stage: check/add before each of the 10 shifts.
    function automatic logic [11:0] bin2bcd(input logic [9:0] b);
        logic [21:0] w;
        w = {12'd0, b};
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (w[10+4*d +: 4] >= BCD_FWD_THRESH)
                    w[10+4*d +: 4] = w[10+4*d +: 4] + BCD_FWD_ADD;
            end
            w = w << 1;
        end
        return w[21:10];
    endfunction

    // Accept one conversion, then watch for valid. lat counts sampling points
    // after the accept edge, and -1 means no valid arrived.
    task automatic convert(input logic [11:0] bcd, output int lat, output logic [9:0] bin,
                           output logic e, output logic [11:0] resid, output logic rdy_low);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        bcd_in  = 12'hFFF;
        lat     = -1;
        bin     = '0;
        e       = 1'b0;
        resid   = '0;
        rdy_low = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (valid) begin
                lat   = i;
                bin   = bin_out;
                e     = err;
                resid = dut.work[21:10];
                break;
            end
            if (ready) rdy_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bcd_in = 12'h000;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (bin_out !== 10'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", bin_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [9:0] b; logic e; logic [11:0] r; logic rl;
        convert(12'h999, lat, b, e, r, rl);
        checks++; if (lat !== 11) begin failures++; $display("FAIL h999_latency got=%0d exp=11", lat); end
        checks++; if (b !== 10'd999) begin failures++; $display("FAIL h999_bin got=%0d exp=999", b); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL h999_err got=%b exp=0", e); end
        checks++; if (r !== 12'h000) begin failures++; $display("FAIL h999_residue got=%h exp=000", r); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL h999_valid_pulse got=%b exp=0", valid); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL h999_ready_return got=%b exp=1", ready); end
        checks++; if (bin_out !== 10'd999) begin failures++; $display("FAIL h999_bin_hold got=%0d exp=999", bin_out); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [9:0] b; logic e; logic [11:0] r; logic rl;
        convert(12'h000, lat, b, e, r, rl);
        checks++; if (lat !== 11) begin failures++; $display("FAIL h000_latency got=%0d exp=11", lat); end
        checks++; if (b !== 10'd0) begin failures++; $display("FAIL h000_bin got=%0d exp=0", b); end
        checks++; if (rl !== 1'b1) begin failures++; $display("FAIL h000_ready_low got=%b exp=1", rl); end
        convert(12'h255, lat, b, e, r, rl);
        checks++; if (lat !== 11) begin failures++; $display("FAIL h255_latency got=%0d exp=11", lat); end
        checks++; if (b !== 10'd255) begin failures++; $display("FAIL h255_bin got=%0d exp=255", b); end
        checks++; if (rl !== 1'b1) begin failures++; $display("FAIL h255_ready_low got=%b exp=1", rl); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL h255_err got=%b exp=0", e); end
    endtask

    task automatic test_illegal();
        logic [11:0] bad_tab [4];
        int lat; logic [9:0] b; logic e; logic [11:0] r; logic rl;
        bad_tab[0] = 12'h1A3;
        bad_tab[1] = 12'hA00;
        bad_tab[2] = 12'h0F0;
        bad_tab[3] = 12'h00A;
        for (int k = 0; k < 4; k++) begin
            convert(bad_tab[k], lat, b, e, r, rl);
            checks++; if (lat !== 1) begin failures++; $display("FAIL illegal_latency in=%h got=%0d exp=1", bad_tab[k], lat); end
            checks++; if (e !== 1'b1) begin failures++; $display("FAIL illegal_err in=%h got=%b exp=1", bad_tab[k], e); end
            checks++; if (b !== 10'd0) begin failures++; $display("FAIL illegal_bin in=%h got=%0d exp=0", bad_tab[k], b); end
        end
        convert(12'h511, lat, b, e, r, rl);
        checks++; if (lat !== 11) begin failures++; $display("FAIL h511_latency got=%0d exp=11", lat); end
        checks++; if (b !== 10'd511) begin failures++; $display("FAIL h511_bin got=%0d exp=511", b); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL h511_err got=%b exp=0", e); end
    endtask

    task automatic test_ignored_start();
        int nvalid; int first; logic [9:0] b;
        @(negedge clk);
        bcd_in = 12'h042;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'h999;
        nvalid = 0;
        first  = -1;
        b      = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 7);
            if (valid) begin
                nvalid++;
                if (first < 0) begin first = i; b = bin_out; end
            end
        end
        start = 1'b0;
        checks++; if (nvalid !== 1) begin failures++; $display("FAIL ignored_start_valid_count got=%0d exp=1", nvalid); end
        checks++; if (first !== 11) begin failures++; $display("FAIL ignored_start_latency got=%0d exp=11", first); end
        checks++; if (b !== 10'd42) begin failures++; $display("FAIL ignored_start_bin got=%0d exp=42", b); end
    endtask

    task automatic test_reset_mid();
        int nvalid;
        int lat; logic [9:0] b; logic e; logic [11:0] r; logic rl;
        @(negedge clk);
        bcd_in = 12'h777;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", err); end
        checks++; if (bin_out !== 10'd0) begin failures++; $display("FAIL midrst_bin got=%0d exp=0", bin_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        checks++; if (nvalid !== 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", nvalid); end
        convert(12'h777, lat, b, e, r, rl);
        checks++; if (b !== 10'd777) begin failures++; $display("FAIL midrst_h777_bin got=%0d exp=777", b); end
        checks++; if (lat !== 11) begin failures++; $display("FAIL midrst_h777_latency got=%0d exp=11", lat); end
    endtask

    task automatic test_start_held();
        int idx [2]; logic [9:0] b [2]; int nv;
        @(negedge clk);
        bcd_in = 12'h123;
        start  = 1'b1;
        @(posedge clk);
        nv = 0;
        idx[0] = -1; idx[1] = -1; b[0] = '0; b[1] = '0;
        for (int i = 1; i <= 30 && nv < 2; i++) begin
            @(negedge clk);
            if (valid) begin
                idx[nv] = i;
                b[nv]   = bin_out;
                nv++;
            end
        end
        start = 1'b0;
        checks++; if (idx[0] !== 11) begin failures++; $display("FAIL held_first_latency got=%0d exp=11", idx[0]); end
        checks++; if (idx[1] !== 23) begin failures++; $display("FAIL held_second_latency got=%0d exp=23", idx[1]); end
        checks++; if (b[0] !== 10'd123 || b[1] !== 10'd123) begin
            failures++; $display("FAIL held_bin got=%0d,%0d exp=123,123", b[0], b[1]);
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_sweep();
        int lat; logic [9:0] b; logic e; logic [11:0] r; logic rl;
        for (int n = 0; n < 1000; n++) begin
            convert(to_bcd(n), lat, b, e, r, rl);
            checks++;
            if (b !== 10'(n) || e !== 1'b0 || lat !== 11 || r !== 12'h000) begin
                failures++;
                $display("FAIL sweep n=%0d got bin=%0d err=%b lat=%0d resid=%h exp bin=%0d err=0 lat=11 resid=000",
                         n, b, e, lat, r, n);
            end
        end
    endtask

    task automatic test_roundtrip();
        int lat; logic [9:0] b; logic e; logic [11:0] r; logic rl;
        for (int n = 0; n < 512; n++) begin
            convert(bin2bcd(10'(n)), lat, b, e, r, rl);
            checks++;
            if (b !== 10'(n) || e !== 1'b0) begin
                failures++;
                $display("FAIL roundtrip n=%0d got bin=%0d err=%b exp bin=%0d err=0", n, b, e, n);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        bcd_in   = 12'h000;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_ignored_start();
        test_reset_mid();
        test_start_held();
        test_sweep();
        test_roundtrip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD (shift-add-3) stage, and turns packed BCD digit entries back into a binary value for arithmetic. It uses reverse double dabble: shift right, then subtract 3 from any digit ≥ 8, one iteration per clock. A start/ready/valid handshake lets it sit between a BCD keypad/entry path and the binary adder datapath.

## Interface
- `DIGITS`, default 3: number of packed BCD digits at the input.
- `BIN_W`, default 10: binary output width.
  - Must satisfy 2^BIN_W ≥ 10^DIGITS; elaboration fails otherwise.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `start` input, 1: request a conversion; sampled only when `ready`=1.
- `bcd_in` input, 4*DIGITS: packed BCD; `[3:0]` is units, `[7:4]` tens, and so on.
- `ready` output, 1: block is idle and will accept `start`.
- `valid` output, 1: one-cycle pulse when the result is final.
- `bin_out` output, BIN_W: converted value; held until the next accepted `start`.
- `err` output, 1: last accepted input contained a digit > 9; held with `bin_out`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `ready`=1.
  - On `start`, capture `bcd_in` into work register {bcd_field[4*DIGITS-1:0], bin_field[BIN_W-1:0]}, with bin_field=0.
  - Clear `err` and set iteration counter=0.
- Digit check at capture: if any digit > 9, skip SHIFT.
  - Go IDLE→DONE with `bin_out`=0 and `err`=1.
- SHIFT, once per cycle:
  - Shift the whole work register right by 1.
  - Then, for each digit of bcd_field: if digit ≥ 8, digit -= 3 (4-bit, no carry out).
  - Counter increments. After BIN_W iterations, go to DONE.
- DONE:
  - `bin_out` ← bin_field; `valid`=1 for this cycle only; `ready`=0.
  - Next cycle returns to IDLE.
- Residue: for legal inputs, bcd_field is all-zero at DONE. A nonzero residue is a design bug, and the bench asserts on it.
- `start` while `ready`=0 is ignored (not queued). `bcd_in` is don't-care outside the accept cycle.
- Counter width: clog2(BIN_W+1).

## Timing
- Accept edge = rising edge of `clk` with `start`=1 and `ready`=1; call it edge 0.
- Legal input:
  - SHIFT occupies edges 1..BIN_W.
  - `valid`=1 in the cycle after edge BIN_W, i.e. latency BIN_W+1 cycles (11 at defaults).
- Illegal input: `valid`=1 in the cycle after edge 0 (latency 1).
- `ready` returns high the cycle after `valid`. Back-to-back throughput is one conversion per BIN_W+2 cycles.
- Reset values: state=IDLE, `ready`=1, `valid`=0, `err`=0, `bin_out`=0, counter=0, work register=0.
- Reset asserted mid-SHIFT aborts the conversion immediately. No `valid` is produced, and the outputs take their reset values.
- `start` held high continuously: a new conversion is accepted on every cycle with `ready`=1, i.e. in each IDLE cycle.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_DIGIT_W`=4, `BCD_ADJ_THRESH`=8, `BCD_ADJ_SUB`=3, `BCD_MAX_DIGIT`=9.
  - FSM state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - The forward binary-to-BCD stage should also use the package constants for its threshold (5) and add (3).
- One sub-module, `bcd_digit_adj`: combinational, 4-bit in → 4-bit out, "≥8 then −3". Generate-instantiated DIGITS times on the shifted bcd_field.
- Everything else (FSM, counter, work register, digit check) lives in the top module.

## Test plan
- `bcd_in`=12'h999, `start` pulse → `valid` at cycle 11 after accept, `bin_out`=10'd999, `err`=0.
- `bcd_in`=12'h000 → `bin_out`=0 at cycle 11. Then `bcd_in`=12'h255 → `bin_out`=10'd255, and `ready` is low throughout.
- `bcd_in`=12'h1A3 → `valid` 1 cycle after accept, `err`=1, `bin_out`=0. A following 12'h511 → `bin_out`=511, `err`=0.
- `start` re-pulsed at cycles 3 and 7 during a 12'h042 conversion → ignored; a single `valid` with `bin_out`=42.
- `rst` asserted at cycle 5 of a 12'h777 conversion → outputs at reset values, no `valid`. After release, 12'h777 → 777.
- Exhaustive sweep 000..999 against a reference model, plus the round-trip check: forward binary-to-BCD(n) → this block → n for n=0..511.
